control_sequencer: RTL and testbench
====================================

# control_sequencer

Hardwired control unit for the basic computer. It steps the 4-bit sequence counter through T0..T6, decodes the instruction held in IR, and issues per-cycle strobes to AR, PC, DR, IR, AC, E, memory and the common-bus select. It is the only block that drives the AC register's clear/load/increment controls and the ALU operation select. It sits between IR/flag outputs and every register's control inputs.

## Interface
- No parameters; word width fixed at 16 and SC width fixed at 4.
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  leaves halt; sampled only while running=0
- ir  in  16  IR contents; valid from T2 onward
- ac_sign  in  1  AC[15]
- ac_zero  in  1  AC==0
- e_flag  in  1  E flip-flop
- dr_zero  in  1  DR==0, as seen by the combinational decode
- running  out  1  S flip-flop
- sc  out  4  current timing step
- bus_sel  out  3  1=AR 2=PC 3=DR 4=AC 5=IR 7=MEM 0=none
- mem_read, mem_write  out  1 each
- ar_load, ar_inc, pc_load, pc_inc, dr_load, dr_inc, ir_load  out  1 each
- ac_clr, ac_load, ac_inc  out  1 each  AC controls; ac_clr has priority in AC
- alu_op  out  3  0=PASS_DR 1=AND 2=ADD 3=CMA 4=SHR 5=SHL
- e_clr, e_cmp, e_load  out  1 each  E controls; e_load takes the ALU carry

## Operation
- State consists only of running and sc. All strobes are combinational from (running, sc, ir, flags) and take effect at the next edge. Every strobe is 0 while running=0.
- Halt: while running=0, sc holds at 0. When start=1, running is set to 1 and sc stays at 0.
- Let D = ir[14:12] and I = ir[15].
- T0: bus_sel=AR source PC; ar_load.
- T1: bus_sel=MEM; mem_read; ir_load; pc_inc.
- T2: bus_sel=IR; ar_load, which loads ir[11:0].
- T3, D≠7, I=1: mem_read; bus_sel=MEM; ar_load (indirect).
- T3, D≠7, I=0: no strobes.
- T3, D=7, I=0 (register-reference): sc←0. Each set bit in ir[11:0] fires its action concurrently:
  - b11 CLA: ac_clr
  - b10 CLE: e_clr
  - b9 CMA: ac_load with alu_op=CMA
  - b8 CME: e_cmp
  - b7 CIR: ac_load and e_load with SHR
  - b6 CIL: ac_load and e_load with SHL
  - b5 INC: ac_inc
  - b4 SPA: pc_inc if !ac_sign
  - b3 SNA: pc_inc if ac_sign
  - b2 SZA: pc_inc if ac_zero
  - b1 SZE: pc_inc if !e_flag
  - b0 HLT: running←0
- Register-reference conflicts: alu_op priority is CMA > CIR > CIL. ac_clr wins over load/inc inside AC. All skip conditions OR into a single pc_inc.
- T3, D=7, I=1 (I/O): NOP, sc←0.
- Memory-reference at T4..T6:
  - AND/ADD/LDA: T4 reads memory into DR. T5 ac_load with alu_op AND/ADD/PASS_DR respectively; ADD also asserts e_load. sc←0.
  - STA: T4 bus_sel=AC, mem_write, sc←0.
  - BUN: T4 bus_sel=AR, pc_load, sc←0.
  - BSA: T4 bus_sel=PC, mem_write, ar_inc. T5 bus_sel=AR, pc_load, sc←0.
  - ISZ: T4 reads memory into DR. T5 dr_inc. T6 bus_sel=DR, mem_write, pc_inc if dr_zero, sc←0.
- Every other step increments sc. sc never exceeds 6.

## Timing
- Reset: running=0, sc=0, all outputs 0, taking effect asynchronously.
- First T0 occurs the cycle after start is sampled.
- Instruction length in cycles, unaffected by I:
  - register-reference and I/O: 4
  - STA and BUN: 5
  - AND, ADD, LDA and BSA: 6
  - ISZ: 7
- HLT: running=0 from the edge that ends T3. start held high during or after HLT restarts execution on the following edge.
- reset_n asserted mid-instruction aborts at once. After release, the block waits for start.

## Structure
- Shared package holds:
  - opcode constants (AND=0, ADD=1, LDA=2, STA=3, BUN=4, BSA=5, ISZ=6, REG/IO=7)
  - register-reference bit indices
  - bus_sel codes
  - alu_op codes
- One sub-module, sequence_counter: 4-bit, async active-low reset, synchronous clr with priority over inc.

## Test plan
- Reset with start=0, then run 10 cycles: running=0, sc=0, all strobes 0. Pulse start: T0 on the next cycle with ar_load=1 and bus_sel=2.
- Fetch 0x7800 (CLA): ac_clr=1 only at T3, sc=0 the next cycle, 4 cycles total. 0x7020 (INC): ac_inc=1 at T3.
- Fetch 0x2005 (LDA), M[5]=0x1234: T4 dr_load with bus_sel=7. T5 ac_load with alu_op=0. Next fetch starts 6 cycles after the first T0.
- Fetch 0x6010 (ISZ) with dr_zero=1 at T6: dr_inc at T5. mem_write and pc_inc at T6. Repeat with dr_zero=0: pc_inc=0 at T6.
- Fetch 0x7004 (SZA): with ac_zero=1, pc_inc=1 at T3; with ac_zero=0, pc_inc=0. Fetch 0x7001 (HLT): running=0 after T3 and sc held at 0 until start.
- Assert reset_n=0 during T5 of an ADD: outputs go to 0 immediately with no ac_load. After release, no activity until start.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// Shared constants for the basic-computer control sequencer:
// opcodes, register-reference bit indices, bus and ALU select codes.
package control_sequencer_pkg;

  localparam int WORD_W = 16;
  localparam int SC_W   = 4;

  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_ADD = 3'd1,
    OP_LDA = 3'd2,
    OP_STA = 3'd3,
    OP_BUN = 3'd4,
    OP_BSA = 3'd5,
    OP_ISZ = 3'd6,
    OP_REG = 3'd7
  } opcode_e;

  localparam int B_CLA = 11;
  localparam int B_CLE = 10;
  localparam int B_CMA = 9;
  localparam int B_CME = 8;
  localparam int B_CIR = 7;
  localparam int B_CIL = 6;
  localparam int B_INC = 5;
  localparam int B_SPA = 4;
  localparam int B_SNA = 3;
  localparam int B_SZA = 2;
  localparam int B_SZE = 1;
  localparam int B_HLT = 0;

  typedef enum logic [2:0] {
    BUS_NONE = 3'd0,
    BUS_AR   = 3'd1,
    BUS_PC   = 3'd2,
    BUS_DR   = 3'd3,
    BUS_AC   = 3'd4,
    BUS_IR   = 3'd5,
    BUS_MEM  = 3'd7
  } bus_e;

  typedef enum logic [2:0] {
    ALU_PASS = 3'd0,
    ALU_AND  = 3'd1,
    ALU_ADD  = 3'd2,
    ALU_CMA  = 3'd3,
    ALU_SHR  = 3'd4,
    ALU_SHL  = 3'd5
  } alu_e;

  // Opcodes that fetch their operand into DR at T4.
  function automatic logic reads_operand(opcode_e op);
    return op inside {OP_AND, OP_ADD, OP_LDA, OP_ISZ};
  endfunction

endpackage

// File: rtl/control_sequencer_sequence_counter.sv
// Timing-step counter SC: clr has priority over inc.
// Ports: clk, rst_n (async low), i_clr, i_inc, o_cnt.
module sequence_counter
  import control_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_clr,
  input  logic            i_inc,
  output logic [SC_W-1:0] o_cnt
);

  logic [SC_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: steps SC through T0..T6, decodes IR,
// drives bus select, memory, register, AC, E and ALU strobes.
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] ir,
  input  logic              ac_sign,
  input  logic              ac_zero,
  input  logic              e_flag,
  input  logic              dr_zero,
  output logic              running,
  output logic [SC_W-1:0]   sc,
  output logic [2:0]        bus_sel,
  output logic              mem_read,
  output logic              mem_write,
  output logic              ar_load,
  output logic              ar_inc,
  output logic              pc_load,
  output logic              pc_inc,
  output logic              dr_load,
  output logic              dr_inc,
  output logic              ir_load,
  output logic              ac_clr,
  output logic              ac_load,
  output logic              ac_inc,
  output logic [2:0]        alu_op,
  output logic              e_clr,
  output logic              e_cmp,
  output logic              e_load
);

  logic            r_running;
  logic            w_run_nxt;
  logic            w_sc_clr;
  logic            w_sc_inc;
  logic [SC_W-1:0] w_sc;
  opcode_e         w_op;
  logic            w_ind;
  logic            w_t0, w_t1, w_t2, w_t3;
  logic            w_t4, w_t5, w_t6;
  logic            w_mref3;
  logic            w_rr;
  logic            w_io;

  assign w_op  = opcode_e'(ir[14:12]);
  assign w_ind = ir[15];

  // Step decodes are qualified by running so halt forces all strobes low.
  assign w_t0 = r_running && (w_sc == 4'd0);
  assign w_t1 = r_running && (w_sc == 4'd1);
  assign w_t2 = r_running && (w_sc == 4'd2);
  assign w_t3 = r_running && (w_sc == 4'd3);
  assign w_t4 = r_running && (w_sc == 4'd4);
  assign w_t5 = r_running && (w_sc == 4'd5);
  assign w_t6 = r_running && (w_sc == 4'd6);

  assign w_mref3 = w_t3 && (w_op != OP_REG);
  assign w_rr    = w_t3 && (w_op == OP_REG) && !w_ind;
  assign w_io    = w_t3 && (w_op == OP_REG) && w_ind;

  sequence_counter u_sc (
    .clk   (clk),
    .rst_n (reset_n),
    .i_clr (w_sc_clr),
    .i_inc (w_sc_inc),
    .o_cnt (w_sc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_running <= 1'b0;
    end else begin
      r_running <= w_run_nxt;
    end
  end

  always_comb begin
    w_run_nxt = r_running;
    w_sc_clr  = 1'b0;
    w_sc_inc  = 1'b0;
    if (!r_running) begin
      w_run_nxt = start;
      w_sc_clr  = 1'b1;
    end else begin
      w_sc_inc = 1'b1;
      if (w_rr && ir[B_HLT]) begin
        w_run_nxt = 1'b0;
      end
      unique case (1'b1)
        w_rr, w_io: w_sc_clr = 1'b1;
        w_t4: w_sc_clr = (w_op == OP_STA) ||
                         (w_op == OP_BUN);
        w_t5: w_sc_clr = w_op inside
                {OP_AND, OP_ADD, OP_LDA, OP_BSA};
        w_t6: w_sc_clr = 1'b1;
        // Recovers from any step beyond T6.
        default: w_sc_clr = (w_sc > 4'd6);
      endcase
    end
  end

  always_comb begin
    bus_sel   = BUS_NONE;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ar_load   = 1'b0;
    ar_inc    = 1'b0;
    pc_load   = 1'b0;
    pc_inc    = 1'b0;
    dr_load   = 1'b0;
    dr_inc    = 1'b0;
    ir_load   = 1'b0;
    ac_clr    = 1'b0;
    ac_load   = 1'b0;
    ac_inc    = 1'b0;
    alu_op    = ALU_PASS;
    e_clr     = 1'b0;
    e_cmp     = 1'b0;
    e_load    = 1'b0;
    unique case (1'b1)
      w_t0: begin
        bus_sel = BUS_PC;
        ar_load = 1'b1;
      end
      w_t1: begin
        bus_sel  = BUS_MEM;
        mem_read = 1'b1;
        ir_load  = 1'b1;
        pc_inc   = 1'b1;
      end
      w_t2: begin
        bus_sel = BUS_IR;
        ar_load = 1'b1;
      end
      w_mref3: begin
        if (w_ind) begin
          bus_sel  = BUS_MEM;
          mem_read = 1'b1;
          ar_load  = 1'b1;
        end
      end
      w_rr: begin
        ac_clr  = ir[B_CLA];
        e_clr   = ir[B_CLE];
        e_cmp   = ir[B_CME];
        ac_inc  = ir[B_INC];
        ac_load = ir[B_CMA] | ir[B_CIR] | ir[B_CIL];
        e_load  = ir[B_CIR] | ir[B_CIL];
        if (ir[B_CMA]) begin
          alu_op = ALU_CMA;
        end else if (ir[B_CIR]) begin
          alu_op = ALU_SHR;
        end else if (ir[B_CIL]) begin
          alu_op = ALU_SHL;
        end
        pc_inc = (ir[B_SPA] & !ac_sign) |
                 (ir[B_SNA] &  ac_sign) |
                 (ir[B_SZA] &  ac_zero) |
                 (ir[B_SZE] & !e_flag);
      end
      w_t4: begin
        if (reads_operand(w_op)) begin
          bus_sel  = BUS_MEM;
          mem_read = 1'b1;
          dr_load  = 1'b1;
        end else begin
          case (w_op)
            OP_STA: begin
              bus_sel   = BUS_AC;
              mem_write = 1'b1;
            end
            OP_BUN: begin
              bus_sel = BUS_AR;
              pc_load = 1'b1;
            end
            OP_BSA: begin
              bus_sel   = BUS_PC;
              mem_write = 1'b1;
              ar_inc    = 1'b1;
            end
            default: ;
          endcase
        end
      end
      w_t5: begin
        case (w_op)
          OP_AND: begin
            ac_load = 1'b1;
            alu_op  = ALU_AND;
          end
          OP_ADD: begin
            ac_load = 1'b1;
            e_load  = 1'b1;
            alu_op  = ALU_ADD;
          end
          OP_LDA: begin
            ac_load = 1'b1;
            alu_op  = ALU_PASS;
          end
          OP_BSA: begin
            bus_sel = BUS_AR;
            pc_load = 1'b1;
          end
          OP_ISZ: dr_inc = 1'b1;
          default: ;
        endcase
      end
      w_t6: begin
        bus_sel   = BUS_DR;
        mem_write = 1'b1;
        pc_inc    = dr_zero;
      end
      default: ;
    endcase
  end

  assign running = r_running;
  assign sc      = w_sc;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed literal checks plus
// randomized instructions against an instruction-level model.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] ir;
  logic        ac_sign, ac_zero, e_flag, dr_zero;
  logic        running;
  logic [3:0]  sc;
  logic [2:0]  bus_sel;
  logic        mem_read, mem_write;
  logic        ar_load, ar_inc, pc_load, pc_inc;
  logic        dr_load, dr_inc, ir_load;
  logic        ac_clr, ac_load, ac_inc;
  logic [2:0]  alu_op;
  logic        e_clr, e_cmp, e_load;

  control_sequencer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .ir        (ir),
    .ac_sign   (ac_sign),
    .ac_zero   (ac_zero),
    .e_flag    (e_flag),
    .dr_zero   (dr_zero),
    .running   (running),
    .sc        (sc),
    .bus_sel   (bus_sel),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .ar_load   (ar_load),
    .ar_inc    (ar_inc),
    .pc_load   (pc_load),
    .pc_inc    (pc_inc),
    .dr_load   (dr_load),
    .dr_inc    (dr_inc),
    .ir_load   (ir_load),
    .ac_clr    (ac_clr),
    .ac_load   (ac_load),
    .ac_inc    (ac_inc),
    .alu_op    (alu_op),
    .e_clr     (e_clr),
    .e_cmp     (e_cmp),
    .e_load    (e_load)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       run;
    logic [3:0] sc;
    logic [2:0] bus;
    logic mr, mw, arl, ari, pcl, pci;
    logic drl, dri, irl, acc, acl, aci;
    logic [2:0] alu;
    logic ec, ecm, el;
  } out_t;

  logic [25:0] act;
  assign act = {running, sc, bus_sel, mem_read, mem_write,
                ar_load, ar_inc, pc_load, pc_inc, dr_load,
                dr_inc, ir_load, ac_clr, ac_load, ac_inc,
                alu_op, e_clr, e_cmp, e_load};

  int total = 0;
  int bad   = 0;
  bit m_run = 1'b0;
  int m_step = 0;

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, a, e, $time);
    end
  endtask

  // Cycles per instruction by class.
  function automatic int ilen(logic [15:0] q);
    case (q[14:12])
      3'd7:       return 4;
      3'd3, 3'd4: return 5;
      3'd6:       return 7;
      default:    return 6;
    endcase
  endfunction

  function automatic out_t exp_out(bit run, int step, logic [15:0] q,
                                   bit sg, bit zr, bit ef, bit dz);
    out_t o;
    logic [2:0] d;
    o = '0;
    d = q[14:12];
    o.run = run;
    o.sc  = 4'(step);
    if (!run) return o;
    if (step == 0) begin
      o.bus = 2; o.arl = 1;
    end else if (step == 1) begin
      o.bus = 7; o.mr = 1; o.irl = 1; o.pci = 1;
    end else if (step == 2) begin
      o.bus = 5; o.arl = 1;
    end else if (step == 3 && d != 7) begin
      if (q[15]) begin o.bus = 7; o.mr = 1; o.arl = 1; end
    end else if (step == 3 && !q[15]) begin
      o.acc = q[11];
      o.ec  = q[10];
      o.ecm = q[8];
      o.aci = q[5];
      o.acl = q[9] | q[7] | q[6];
      o.el  = q[7] | q[6];
      o.alu = q[9] ? 3'd3 : q[7] ? 3'd4 : q[6] ? 3'd5 : 3'd0;
      o.pci = (q[4] & !sg) | (q[3] & sg) | (q[2] & zr) | (q[1] & !ef);
    end else if (step == 4) begin
      case (d)
        0, 1, 2, 6: begin o.bus = 7; o.mr = 1; o.drl = 1; end
        3: begin o.bus = 4; o.mw = 1; end
        4: begin o.bus = 1; o.pcl = 1; end
        5: begin o.bus = 2; o.mw = 1; o.ari = 1; end
        default: ;
      endcase
    end else if (step == 5) begin
      case (d)
        0: begin o.acl = 1; o.alu = 1; end
        1: begin o.acl = 1; o.alu = 2; o.el = 1; end
        2: begin o.acl = 1; o.alu = 0; end
        5: begin o.bus = 1; o.pcl = 1; end
        6: o.dri = 1;
        default: ;
      endcase
    end else if (step == 6) begin
      o.bus = 3; o.mw = 1; o.pci = dz;
    end
    return o;
  endfunction

  task automatic check_cycle();
    out_t e;
    e = exp_out(m_run, m_step, ir, ac_sign, ac_zero, e_flag, dr_zero);
    chk($sformatf("cycle step%0d ir%04h", m_step, ir), 32'(act), 32'(e));
  endtask

  task automatic model_step();
    if (!reset_n) begin
      m_run = 0; m_step = 0;
    end else if (!m_run) begin
      m_step = 0;
      if (start) m_run = 1;
    end else begin
      if (m_step == 3 && ir[14:12] == 3'd7 && !ir[15] && ir[0]) m_run = 0;
      m_step = (m_step + 1) % ilen(ir);
    end
  endtask

  // Bench idles at posedge+1 between calls.
  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic skip(int n);
    repeat (n) tick();
  endtask

  task automatic settle();
    #2;
  endtask

  function automatic logic [15:0] rand_ir();
    logic [15:0] q;
    q = 16'($urandom);
    if (q[14:12] == 3'd7 && !q[15]) q[0] = ($urandom_range(0, 7) == 0);
    return q;
  endfunction

  initial begin
    reset_n = 0; start = 0; ir = 16'h0000;
    ac_sign = 0; ac_zero = 0; e_flag = 0; dr_zero = 0;
    skip(2);
    reset_n = 1;
    skip(10);
    settle();
    chk("idle_running", 32'(running), 32'd0);
    chk("idle_sc", 32'(sc), 32'd0);
    start = 1;
    skip(1);
    start = 0;
    ir = 16'h7800;
    settle();
    chk("t0_ar_load", 32'(ar_load), 32'd1);
    chk("t0_bus_sel", 32'(bus_sel), 32'd2);
    skip(3); settle();
    chk("cla_ac_clr", 32'(ac_clr), 32'd1);
    chk("cla_sc", 32'(sc), 32'd3);
    skip(1); settle();
    chk("cla_wrap_sc", 32'(sc), 32'd0);
    chk("cla_wrap_clr", 32'(ac_clr), 32'd0);
    ir = 16'h7020;
    skip(3); settle();
    chk("inc_ac_inc", 32'(ac_inc), 32'd1);
    skip(1); settle();
    ir = 16'h2005;
    skip(4); settle();
    chk("lda_dr_load", 32'(dr_load), 32'd1);
    chk("lda_bus_mem", 32'(bus_sel), 32'd7);
    skip(1); settle();
    chk("lda_ac_load", 32'(ac_load), 32'd1);
    chk("lda_alu", 32'(alu_op), 32'd0);
    skip(1); settle();
    chk("lda_len_sc", 32'(sc), 32'd0);
    chk("lda_len_ar", 32'(ar_load), 32'd1);
    ir = 16'h6010; dr_zero = 0;
    skip(5); settle();
    chk("isz_dr_inc", 32'(dr_inc), 32'd1);
    dr_zero = 1;
    skip(1); settle();
    chk("isz_mw", 32'(mem_write), 32'd1);
    chk("isz_skip", 32'(pc_inc), 32'd1);
    skip(1); settle();
    dr_zero = 0;
    skip(6); settle();
    chk("isz_noskip", 32'(pc_inc), 32'd0);
    chk("isz_mw2", 32'(mem_write), 32'd1);
    skip(1); settle();
    ir = 16'h7004; ac_zero = 1;
    skip(3); settle();
    chk("sza_skip", 32'(pc_inc), 32'd1);
    skip(1); settle();
    ac_zero = 0;
    skip(3); settle();
    chk("sza_noskip", 32'(pc_inc), 32'd0);
    skip(1); settle();
    ir = 16'h7001;
    skip(3); settle();
    chk("hlt_t3_run", 32'(running), 32'd1);
    skip(1); settle();
    chk("hlt_run", 32'(running), 32'd0);
    chk("hlt_sc", 32'(sc), 32'd0);
    skip(3); settle();
    chk("hlt_hold_run", 32'(running), 32'd0);
    chk("hlt_hold_sc", 32'(sc), 32'd0);
    start = 1;
    skip(1); settle();
    chk("restart_run", 32'(running), 32'd1);
    start = 0;
    ir = 16'h1003;
    skip(5); settle();
    chk("add_t5_load", 32'(ac_load), 32'd1);
    chk("add_t5_eload", 32'(e_load), 32'd1);
    reset_n = 0;
    #1;
    chk("reset_abort", 32'(act), 32'd0);
    m_run = 0; m_step = 0;
    skip(2);
    reset_n = 1;
    skip(5); settle();
    chk("post_reset_idle", 32'(running), 32'd0);
    start = 1;
    skip(1);
    for (int k = 0; k < 400; k++) begin
      if (!m_run || m_step == 0) ir = rand_ir();
      ac_sign = 1'($urandom_range(0, 1));
      ac_zero = 1'($urandom_range(0, 1));
      e_flag  = 1'($urandom_range(0, 1));
      dr_zero = 1'($urandom_range(0, 1));
      start   = ($urandom_range(0, 3) == 0);
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
